// File: rtl/barrier_pipe_if.sv
// barrier_pipe_if: row stream handshake, flush and per-stage enables for barrier_pipe_ctrl.
interface barrier_pipe_if #(
    parameter int STAGES = 4,
    parameter int RW     = 3
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic              out_ready;
    logic              out_valid;
    logic [STAGES-1:0] stage_en;
    logic [RW-1:0]     out_row;
    logic              out_last;
    logic              block_done;
    logic              busy;
    modport master (
        output flush, in_valid, out_ready,
        input  in_ready, out_valid, stage_en, out_row, out_last, block_done, busy
    );
    modport slave (
        input  flush, in_valid, out_ready,
        output in_ready, out_valid, stage_en, out_row, out_last, block_done, busy
    );
endinterface

// File: rtl/barrier_pipe_ctrl.sv
// barrier_pipe_ctrl: per-stage enables for a reg_barrier chain with bubble collapse and row tagging.
module barrier_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int ROWS   = 8,
    parameter int RW     = 3
) (
    input logic            clk,
    input logic            rst_n,
    barrier_pipe_if.slave  bus
);
    logic [STAGES-1:0]         v_q, v_d;
    logic [STAGES-1:0][RW-1:0] t_q, t_d;
    logic [RW-1:0]             wcnt_q, wcnt_d;
    logic                      done_q, done_d;
    logic [STAGES-1:0]         r, src_v, en;
    logic [STAGES-1:0][RW-1:0] src_t;
    logic                      accept, out_hs;
    // r[k] unrolled: stage k can load unless it and everything after it is full and stalled
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        assign r[k] = bus.out_ready | ~&v_q[STAGES-1:k];
        if (k == 0) begin : g_head
            assign src_v[k] = bus.in_valid;
            assign src_t[k] = wcnt_q;
        end else begin : g_body
            assign src_v[k] = v_q[k-1];
            assign src_t[k] = t_q[k-1];
        end
    end
    assign en             = r & src_v & {STAGES{~bus.flush & rst_n}};
    assign bus.stage_en   = en;
    assign bus.in_ready   = r[0] & ~bus.flush & rst_n;
    assign accept         = bus.in_valid & bus.in_ready;
    assign bus.out_valid  = v_q[STAGES-1];
    assign bus.out_row    = v_q[STAGES-1] ? t_q[STAGES-1] : '0;
    assign bus.out_last   = bus.out_valid & (bus.out_row == RW'(ROWS-1));
    assign out_hs         = bus.out_valid & bus.out_ready;
    assign bus.block_done = done_q;
    assign bus.busy       = |v_q;
    always_comb begin
        v_d    = v_q;
        t_d    = t_q;
        wcnt_d = wcnt_q;
        done_d = out_hs & bus.out_last & ~bus.flush;
        if (bus.flush) begin
            v_d    = '0;
            t_d    = '0;
            wcnt_d = '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_d[k] = r[k] ? src_v[k] : v_q[k];
                t_d[k] = en[k] ? src_t[k] : t_q[k];
            end
            if (accept) wcnt_d = (wcnt_q == RW'(ROWS-1)) ? '0 : wcnt_q + RW'(1);
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q    <= '0;
            t_q    <= '0;
            wcnt_q <= '0;
            done_q <= 1'b0;
        end else begin
            v_q    <= v_d;
            t_q    <= t_d;
            wcnt_q <= wcnt_d;
            done_q <= done_d;
        end
    end
endmodule

// File: tb/tb_barrier_pipe_ctrl.sv
// tb_barrier_pipe_ctrl: directed checks of streaming, stall, bubble collapse, flush and async reset.
module tb_barrier_pipe_ctrl;
    localparam int S = 4;
    localparam int R = 8;
    localparam int W = 3;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;
    barrier_pipe_if #(.STAGES(S), .RW(W)) bus ();
    barrier_pipe_ctrl #(.STAGES(S), .ROWS(R), .RW(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic check_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(bus.in_ready), 0);
        chk({tag, "_stage_en"}, 32'(bus.stage_en), 0);
        chk({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        chk({tag, "_out_last"}, 32'(bus.out_last), 0);
        chk({tag, "_busy"}, 32'(bus.busy), 0);
        chk({tag, "_out_row"}, 32'(bus.out_row), 0);
        chk({tag, "_block_done"}, 32'(bus.block_done), 0);
    endtask
    // n rows back-to-back from tag 0; row i is at the last barrier after tick i+3
    task automatic stream(input int n);
        int  dones;
        bit  vld;
        dones = 0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < n + 4; i++) begin
            bus.in_valid = (i < n);
            #1;
            if (i < n) chk("stream_in_ready", 32'(bus.in_ready), 1);
            tick;
            vld = (i >= 3) && (i < n + 3);
            chk("stream_out_valid", 32'(bus.out_valid), 32'(vld));
            chk("stream_out_row", 32'(bus.out_row), vld ? 32'((i - 3) % R) : 0);
            chk("stream_out_last", 32'(bus.out_last), 32'(vld && ((i - 3) % R == R - 1)));
            chk("stream_block_done", 32'(bus.block_done),
                32'((i >= 4) && (i - 4 < n) && ((i - 4) % R == R - 1)));
            dones += int'(bus.block_done);
        end
        chk("stream_done_count", 32'(dones), 32'(n / R));
        chk("stream_idle_busy", 32'(bus.busy), 0);
    endtask
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
    initial begin
        bus.flush = 1'b0;
        bus.in_valid = 1'b1;
        bus.out_ready = 1'b0;
        #3;
        check_reset_outputs("reset");
        #9 rst_n = 1'b1;
        stream(16);
        // stall: fill, hold out_ready low, then drain
        bus.out_ready = 1'b0;
        bus.in_valid = 1'b1;
        repeat (4) tick;
        chk("stall_full_valid", 32'(bus.out_valid), 1);
        chk("stall_full_row", 32'(bus.out_row), 0);
        chk("stall_full_busy", 32'(bus.busy), 1);
        for (int c = 0; c < 5; c++) begin
            chk("stall_in_ready", 32'(bus.in_ready), 0);
            chk("stall_stage_en", 32'(bus.stage_en), 0);
            tick;
            chk("stall_row_held", 32'(bus.out_row), 0);
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("drain_valid", 32'(bus.out_valid), 1);
            chk("drain_row", 32'(bus.out_row), 32'(j));
            tick;
        end
        chk("drain_empty", 32'(bus.out_valid), 0);
        bus.flush = 1'b1;
        tick;
        bus.flush = 1'b0;
        // bubble collapse against a stalled output
        bus.out_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            bus.in_valid = (c % 2 == 0);
            #1;
            if (bus.in_valid) chk("bubble_in_ready", 32'(bus.in_ready), 1);
            tick;
        end
        bus.in_valid = 1'b1;
        #1;
        chk("bubble_full_in_ready", 32'(bus.in_ready), 0);
        chk("bubble_full_stage_en", 32'(bus.stage_en), 0);
        chk("bubble_full_busy", 32'(bus.busy), 1);
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1;
            chk("bubble_out_valid", 32'(bus.out_valid), 1);
            chk("bubble_out_row", 32'(bus.out_row), 32'(j));
            tick;
        end
        chk("bubble_empty", 32'(bus.out_valid), 0);
        // flush with tag 7 at the output being taken in the flush cycle
        bus.in_valid = 1'b1;
        repeat (7) tick;
        chk("preflush_row", 32'(bus.out_row), 7);
        chk("preflush_last", 32'(bus.out_last), 1);
        bus.flush = 1'b1;
        #1;
        chk("flush_in_ready", 32'(bus.in_ready), 0);
        chk("flush_stage_en", 32'(bus.stage_en), 0);
        tick;
        bus.flush = 1'b0;
        chk("postflush_busy", 32'(bus.busy), 0);
        chk("postflush_valid", 32'(bus.out_valid), 0);
        chk("postflush_done", 32'(bus.block_done), 0);
        tick;
        bus.in_valid = 1'b0;
        chk("postflush_done2", 32'(bus.block_done), 0);
        repeat (3) tick;
        chk("postflush_tag_valid", 32'(bus.out_valid), 1);
        chk("postflush_tag", 32'(bus.out_row), 0);
        tick;
        chk("postflush_drained", 32'(bus.out_valid), 0);
        // async reset mid-stream, between edges
        bus.in_valid = 1'b1;
        repeat (6) tick;
        chk("prereset_busy", 32'(bus.busy), 1);
        #3 rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        #2 rst_n = 1'b1;
        bus.in_valid = 1'b0;
        stream(8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
